mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch stage and the data-access (MEM) stage of the 5-stage core.
- Runs one bus transaction at a time.
- Drives per-requester stall and done signals back into the pipeline.
- Discards fetch results made stale by a taken branch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits; after that, fetch wins the next grant.
- WAIT_LIMIT, 15: maximum cycles `mem_valid` may stay high without `mem_ready` before timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- if_req  input  1  fetch request.
- if_addr  input  32  fetch address; word-aligned.
- if_flush  input  1  taken branch; discard the in-flight or next fetch result.
- if_rdata  output  32  fetched instruction.
- if_done  output  1  one-cycle pulse; `if_rdata` is valid.
- if_stall  output  1  fetch stage must hold.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_wstrb  input  4  store byte enables.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data.
- d_done  output  1  one-cycle pulse; data access complete.
- d_stall  output  1  MEM stage must hold.
- bus_err  output  1  one-cycle pulse on timeout.
- mem_valid  output  1  bus request.
- mem_we  output  1  bus write.
- mem_wstrb  output  4  bus byte enables; 0 on reads.
- mem_addr  output  32  bus address.
- mem_wdata  output  32  bus write data.
- mem_ready  input  1  bus completion; `mem_rdata` valid in the same cycle.
- mem_rdata  input  32  bus read data.

Behaviour:
- **States:** IDLE, IF_BUSY, D_BUSY. All state and outputs are registered except the stalls.
- **Reset values (async):** state = IDLE. `mem_valid`, `mem_we`, `if_done`, `d_done`, `bus_err` = 0. `mem_wstrb` = 0. `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0. Starve counter = 0, wait counter = 0, flush flag = 0.
- **IDLE grant rule:**
  - `d_req` wins over `if_req`, unless starve counter == STARVE_LIMIT and `if_req`=1; then fetch wins.
  - On grant, latch address, data and strobes into the `mem_*` registers and set `mem_valid`=1 on the next edge.
  - Enter IF_BUSY or D_BUSY.
- **Starve counter:**
  - Increments on each data grant made while `if_req`=1, saturating at STARVE_LIMIT.
  - Clears on each fetch grant, and whenever `if_req`=0 in IDLE.
- **Busy states:**
  - `mem_*` outputs are held constant until `mem_ready`.
  - Wait counter increments each cycle `mem_ready`=0.
  - On `mem_ready`:
    - capture `mem_rdata` into `if_rdata` or `d_rdata`;
    - pulse the matching done next cycle;
    - drop `mem_valid`;
    - return to IDLE.
  - Minimum access latency: 2 cycles from request to done, with zero-wait memory. The next grant is possible in the cycle after done.
- **Timeout:** when wait counter reaches WAIT_LIMIT without `mem_ready`:
  - drop `mem_valid`;
  - pulse `bus_err` and the owner's done;
  - return 0 as read data;
  - go to IDLE.
- **Flush:**
  - `if_flush`=1 during IF_BUSY sets the flush flag. The transaction still completes on the bus, but `if_done` is suppressed and `if_rdata` is not updated. The flag clears on completion.
  - `if_flush` in IDLE has no effect.
  - `if_flush` in D_BUSY has no effect.
- **Stalls (combinational):**
  - `if_stall` = `if_req` & ~`if_done`.
  - `d_stall` = `d_req` & ~`d_done`.
- **Requester withdrawal:** a requester dropping its req mid-transaction does not abort the transaction; done still pulses.
- **Reset mid-transaction:** the transaction is abandoned, `mem_valid` falls immediately, and no done pulse is issued.
- **Simultaneous events:**
  - `mem_ready` in the same cycle as `if_flush` counts as flushed.
  - `mem_ready` in the same cycle the wait counter hits WAIT_LIMIT counts as success; no `bus_err`.

Test Plan:
- **Zero-wait fetch:** `if_req`=1, `if_addr`=0x80000000, `mem_ready` tied 1, `mem_rdata`=0x24080005 → `mem_valid` high 1 cycle; `if_done`=1 with `if_rdata`=0x24080005 two cycles after request; `if_stall` low in that cycle.
- **Contention:** `if_req`=1 and `d_req`=1 (load, 0x1000) together → data granted first, `d_done` pulses, then fetch granted. `mem_addr` sequence is 0x1000 then the fetch address.
- **Starvation:** `d_req` held 1 continuously, `if_req`=1, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, then data resumes; repeating pattern.
- **Store with wait states:** `d_we`=1, `d_wstrb`=0x3, `d_wdata`=0xDEADBEEF, `mem_ready` after 3 cycles → `mem_*` stable for all 4 cycles; `d_done` once; `bus_err`=0.
- **Flush:** `if_flush` pulsed during IF_BUSY, `mem_ready` 2 cycles later → no `if_done`, `if_rdata` unchanged; next fetch proceeds normally.
- **Timeout and reset:** `mem_ready` held 0 → after 15 cycles `bus_err`=1 and done pulse with rdata 0. Separately, `rst` asserted mid-D_BUSY → `mem_valid`=0 immediately, state IDLE, no `d_done`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported memory bus arbiter shared by the fetch and MEM stages.
// One transaction at a time; data has priority, bounded by a fetch-starvation limit.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_LIMIT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        bus_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;

    state_e        state_q;
    logic [SW-1:0] starve_q;
    logic [WW-1:0] wait_q;
    logic          flush_q;
    logic          mem_valid_q, mem_we_q;
    logic [3:0]    mem_wstrb_q;
    logic [31:0]   mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;
    logic          if_done_q, d_done_q, bus_err_q;

    logic          fetch_win, gap, timeout, flushed;
    logic [WW-1:0] wait_d;
    logic [SW-1:0] starve_d;

    assign fetch_win = if_req && (!d_req || starve_q == SW'(STARVE_LIMIT));
    // The done cycle is a recovery cycle: the requester still shows its old request.
    assign gap       = if_done_q | d_done_q;
    assign wait_d    = wait_q + WW'(1);
    assign timeout   = !mem_ready && (wait_d == WW'(WAIT_LIMIT));
    assign flushed   = flush_q | if_flush;
    assign starve_d  = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            flush_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!if_req) starve_q <= '0;
                    if (!gap && (if_req || d_req)) begin
                        mem_valid_q <= 1'b1;
                        wait_q      <= '0;
                        flush_q     <= 1'b0;
                        if (fetch_win) begin
                            state_q     <= IF_BUSY;
                            mem_addr_q  <= if_addr;
                            mem_we_q    <= 1'b0;
                            mem_wstrb_q <= '0;
                            mem_wdata_q <= '0;
                            starve_q    <= '0;
                        end else begin
                            state_q     <= D_BUSY;
                            mem_addr_q  <= d_addr;
                            mem_we_q    <= d_we;
                            mem_wstrb_q <= d_we ? d_wstrb : 4'h0;
                            mem_wdata_q <= d_wdata;
                            if (if_req) starve_q <= starve_d;
                        end
                    end
                end
                IF_BUSY: begin
                    if (mem_ready || timeout) begin
                        state_q     <= IDLE;
                        mem_valid_q <= 1'b0;
                        flush_q     <= 1'b0;
                        bus_err_q   <= !mem_ready;
                        // A flushed fetch still finishes on the bus but its result is dropped.
                        if (!flushed) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_ready ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_q <= wait_d;
                        if (if_flush) flush_q <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (mem_ready || timeout) begin
                        state_q     <= IDLE;
                        mem_valid_q <= 1'b0;
                        bus_err_q   <= !mem_ready;
                        d_done_q    <= 1'b1;
                        d_rdata_q   <= mem_ready ? mem_rdata : 32'h0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_stall   = d_req & ~d_done_q;
    assign bus_err   = bus_err_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the grant and completion rules.
module tb_mem_port_arbiter;

    localparam int SL = 4;
    localparam int WL = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, d_done, d_stall, bus_err, mem_valid, mem_we;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;
    int mem_waits = 0;
    bit mem_hang = 1'b0;
    int mcnt = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .bus_err(bus_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hA408_0005;
    endfunction

    // Memory: answers after mem_waits stall cycles, or never while mem_hang is set.
    always @(negedge clk) begin
        if (rst || !mem_valid) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else begin
            mem_ready = !mem_hang && (mcnt >= mem_waits);
            mcnt++;
        end
        mem_rdata = rd_of(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h8000_0000; d_addr = 32'h100;
        repeat (3) tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
        checks++; if (if_done !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b exp 000", if_done, d_done, bus_err); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_bus addr %h wdata %h strb %h we %b exp zeros", mem_addr, mem_wdata, mem_wstrb, mem_we); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0 0", if_rdata, d_rdata); end
        checks++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL reset_stalls got %b %b exp 1 1", if_stall, d_stall); end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_fetch();
        mem_waits = 0; if_addr = 32'h8000_0000; if_req = 1'b1;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL zw_grant valid %b addr %h we %b strb %h exp 1 80000000 0 0", mem_valid, mem_addr, mem_we, mem_wstrb); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL zw_stall_busy got %b exp 1", if_stall); end
        tick();
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h2408_0005) begin errors++; $display("FAIL zw_done done %b rdata %h exp 1 24080005", if_done, if_rdata); end
        checks++; if (if_stall !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL zw_release stall %b valid %b exp 0 0", if_stall, mem_valid); end
        if_req = 1'b0;
        tick();
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL zw_pulse_width got %b exp 0", if_done); end
    endtask

    task automatic test_contention();
        logic [31:0] seq[$];
        int d_at, i_at;
        logic pv;
        d_at = -1; i_at = -1; pv = mem_valid;
        mem_waits = 0; d_addr = 32'h1000; d_we = 1'b0; if_addr = 32'h8000_0100;
        d_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 30 && (d_at < 0 || i_at < 0); c++) begin
            tick();
            if (mem_valid && !pv) seq.push_back(mem_addr);
            pv = mem_valid;
            if (d_done) begin d_at = c; d_req = 1'b0; end
            if (if_done) begin i_at = c; if_req = 1'b0; end
        end
        checks++; if (d_at < 0 || i_at < 0) begin errors++; $display("FAIL cont_timeout d_at %0d i_at %0d exp both done", d_at, i_at); end
        checks++; if (seq.size() != 2) begin errors++; $display("FAIL cont_grants got %0d exp 2", seq.size()); end
        checks++; if (seq.size() < 1 || seq[0] !== 32'h1000) begin errors++; $display("FAIL cont_first_addr exp 00001000"); end
        checks++; if (seq.size() < 2 || seq[1] !== 32'h8000_0100) begin errors++; $display("FAIL cont_second_addr exp 80000100"); end
        checks++; if (!(d_at < i_at)) begin errors++; $display("FAIL cont_order d_at %0d i_at %0d exp data first", d_at, i_at); end
        checks++; if (d_rdata !== rd_of(32'h1000) || if_rdata !== rd_of(32'h8000_0100)) begin errors++; $display("FAIL cont_rdata got %h %h exp %h %h", d_rdata, if_rdata, rd_of(32'h1000), rd_of(32'h8000_0100)); end
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] own[$];
        logic [31:0] ex, got;
        logic pv;
        int streak, nf;
        pv = mem_valid; mem_waits = 0;
        if_addr = 32'h8000_0200; d_addr = 32'h2000; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 300 && own.size() < 15; c++) begin
            tick();
            if (mem_valid && !pv) own.push_back(mem_addr);
            pv = mem_valid;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (6) tick();
        checks++; if (own.size() != 15) begin errors++; $display("FAIL starve_grant_count got %0d exp 15", own.size()); end
        streak = 0; nf = 0;
        for (int k = 0; k < 15; k++) begin
            if (streak == SL) begin ex = if_addr; streak = 0; end
            else begin ex = d_addr; streak++; end
            got = (k < own.size()) ? own[k] : 32'hFFFF_FFFF;
            if (got == if_addr) nf++;
            checks++; if (got !== ex) begin errors++; $display("FAIL starve_grant_%0d got %h exp %h", k, got, ex); end
        end
        checks++; if (nf != 3) begin errors++; $display("FAIL starve_fetch_count got %0d exp 3", nf); end
    endtask

    task automatic test_store_waits();
        int vcyc, unstable, dn, be;
        logic done_stall, mid_stall;
        vcyc = 0; unstable = 0; dn = 0; be = 0; done_stall = 1'bx; mid_stall = 1'bx;
        mem_waits = 3; d_we = 1'b1; d_wstrb = 4'h3; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h3000; d_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mem_valid) begin
                vcyc++;
                if (vcyc == 2) mid_stall = d_stall;
                if (mem_addr !== 32'h3000 || mem_we !== 1'b1 || mem_wstrb !== 4'h3 || mem_wdata !== 32'hDEAD_BEEF) unstable++;
            end
            if (bus_err) be++;
            if (d_done) begin dn++; done_stall = d_stall; d_req = 1'b0; end
        end
        checks++; if (vcyc != 4) begin errors++; $display("FAIL store_valid_cycles got %0d exp 4", vcyc); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL store_bus_stable got %0d changes exp 0", unstable); end
        checks++; if (dn != 1) begin errors++; $display("FAIL store_done_count got %0d exp 1", dn); end
        checks++; if (be != 0) begin errors++; $display("FAIL store_bus_err got %0d exp 0", be); end
        checks++; if (mid_stall !== 1'b1 || done_stall !== 1'b0) begin errors++; $display("FAIL store_stall mid %b done %b exp 1 0", mid_stall, done_stall); end
        mem_waits = 0; d_we = 1'b0; d_wstrb = 4'h0;
    endtask

    task automatic test_flush();
        bit got;
        int ndone, nerr;
        mem_waits = 0; if_addr = 32'h8000_0300; if_req = 1'b1; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin tick(); if (if_done) got = 1'b1; end
        if_req = 1'b0;
        checks++; if (!got || if_rdata !== rd_of(32'h8000_0300)) begin errors++; $display("FAIL flush_pre_fetch done %b rdata %h exp 1 %h", got, if_rdata, rd_of(32'h8000_0300)); end
        tick();
        mem_waits = 3; if_addr = 32'h8000_0400; if_req = 1'b1;
        tick(); tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0400) begin errors++; $display("FAIL flush_inflight valid %b addr %h exp 1 80000400", mem_valid, mem_addr); end
        if_flush = 1'b1; if_req = 1'b0;
        tick();
        if_flush = 1'b0;
        ndone = 0; nerr = 0;
        for (int c = 0; c < 8; c++) begin tick(); if (if_done) ndone++; if (bus_err) nerr++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL flush_done_suppressed got %0d exp 0", ndone); end
        checks++; if (if_rdata !== rd_of(32'h8000_0300)) begin errors++; $display("FAIL flush_rdata_held got %h exp %h", if_rdata, rd_of(32'h8000_0300)); end
        checks++; if (mem_valid !== 1'b0 || nerr != 0) begin errors++; $display("FAIL flush_bus_done valid %b err %0d exp 0 0", mem_valid, nerr); end
        mem_waits = 0; if_addr = 32'h8000_0500; if_req = 1'b1; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin tick(); if (if_done) got = 1'b1; end
        if_req = 1'b0;
        checks++; if (!got || if_rdata !== rd_of(32'h8000_0500)) begin errors++; $display("FAIL flush_next_fetch done %b rdata %h exp 1 %h", got, if_rdata, rd_of(32'h8000_0500)); end
        tick();
    endtask

    task automatic test_timeout();
        int vcyc, be, dn;
        logic [31:0] rd;
        logic same;
        vcyc = 0; be = 0; dn = 0; rd = 32'hFFFF_FFFF; same = 1'b0;
        mem_hang = 1'b1; d_addr = 32'h4000; d_we = 1'b0; d_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mem_valid) vcyc++;
            if (bus_err) begin be++; same = d_done; rd = d_rdata; end
            if (d_done) begin dn++; d_req = 1'b0; end
        end
        mem_hang = 1'b0;
        checks++; if (vcyc != WL) begin errors++; $display("FAIL timeout_valid_cycles got %0d exp %0d", vcyc, WL); end
        checks++; if (be != 1 || dn != 1) begin errors++; $display("FAIL timeout_pulses err %0d done %0d exp 1 1", be, dn); end
        checks++; if (same !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_result done_with_err %b rdata %h exp 1 0", same, rd); end
    endtask

    task automatic test_reset_mid();
        int dn, vv;
        dn = 0; vv = 0;
        mem_hang = 1'b1; d_addr = 32'h5000; d_we = 1'b0; d_req = 1'b1;
        repeat (3) tick();
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", mem_valid); end
        rst = 1'b1; d_req = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_async got %b exp 0", mem_valid); end
        tick();
        rst = 1'b0; mem_hang = 1'b0;
        for (int c = 0; c < 6; c++) begin tick(); if (d_done) dn++; if (mem_valid) vv++; end
        checks++; if (dn != 0 || vv != 0) begin errors++; $display("FAIL rstmid_quiet done %0d valid %0d exp 0 0", dn, vv); end
    endtask

    task automatic test_random();
        logic pend_if, pend_d, pv, is_f;
        int streak, grants, dones, nerr, cyc;
        logic [31:0] r;
        pend_if = 1'b0; pend_d = 1'b0; pv = mem_valid;
        streak = 0; grants = 0; dones = 0; nerr = 0; cyc = 0;
        while (cyc < 900 && (cyc < 700 || pend_if || pend_d)) begin
            tick();
            cyc++;
            if (bus_err) nerr++;
            if (mem_valid && !pv) begin
                grants++;
                is_f = pend_if && (!pend_d || streak == SL);
                checks++;
                if (!pend_if && !pend_d) begin
                    errors++; $display("FAIL rand_grant_unrequested addr %h", mem_addr);
                end else if (is_f) begin
                    if (mem_addr !== if_addr || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
                        errors++; $display("FAIL rand_fetch_grant got %h we %b exp %h (data addr %h)", mem_addr, mem_we, if_addr, d_addr);
                    end
                    streak = 0;
                end else begin
                    if (mem_addr !== d_addr || mem_we !== d_we || mem_wstrb !== (d_we ? d_wstrb : 4'h0) || mem_wdata !== d_wdata) begin
                        errors++; $display("FAIL rand_data_grant got %h/%b/%h/%h exp %h/%b/%h/%h", mem_addr, mem_we, mem_wstrb, mem_wdata, d_addr, d_we, (d_we ? d_wstrb : 4'h0), d_wdata);
                    end
                    streak = pend_if ? ((streak < SL) ? streak + 1 : SL) : 0;
                end
                mem_waits = int'($urandom_range(0, 3));
            end
            pv = mem_valid;
            if (if_done) begin
                dones++;
                checks++; if (!pend_if || if_rdata !== rd_of(if_addr)) begin errors++; $display("FAIL rand_if_done pend %b rdata %h exp %h", pend_if, if_rdata, rd_of(if_addr)); end
                pend_if = 1'b0; if_req = 1'b0;
            end
            if (d_done) begin
                dones++;
                checks++; if (!pend_d || (!d_we && d_rdata !== rd_of(d_addr))) begin errors++; $display("FAIL rand_d_done pend %b rdata %h exp %h", pend_d, d_rdata, rd_of(d_addr)); end
                pend_d = 1'b0; d_req = 1'b0;
            end
            if (cyc < 700) begin
                if (!pend_if && $urandom_range(0, 2) == 0) begin
                    r = $urandom();
                    if_addr = {r[31:2], 2'b00}; pend_if = 1'b1; if_req = 1'b1;
                end
                if (!pend_d && $urandom_range(0, 2) == 0) begin
                    d_addr = $urandom(); d_wdata = $urandom();
                    d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom_range(1, 15));
                    pend_d = 1'b1; d_req = 1'b1;
                end
            end
        end
        checks++; if (pend_if || pend_d) begin errors++; $display("FAIL rand_drain pending if %b d %b exp 0 0", pend_if, pend_d); end
        checks++; if (nerr != 0) begin errors++; $display("FAIL rand_bus_err got %0d exp 0", nerr); end
        checks++; if (grants != dones || grants < 100) begin errors++; $display("FAIL rand_throughput grants %0d dones %0d exp equal and >=100", grants, dones); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_contention();
        test_starvation();
        test_store_waits();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
